// File: rtl/bsg_manycore_wh_link_arbiter.sv
// Shares one wormhole memory link between two requester links: packet-locked round-robin forward
// arbitration, cord-based return demux. Optional per-port counters under BSG_MANYCORE_WH_ARB_STATS_EN.
module bsg_manycore_wh_link_arbiter #(
  parameter int wh_flit_width_p = 32,
  parameter int wh_cord_width_p = 7,
  parameter int wh_len_width_p  = 4,
  parameter int wh_cid_width_p  = 1,
  parameter int split_cord_p    = 0
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [2*(wh_flit_width_p+2)-1:0] req_link_sif_i,
  output logic [2*(wh_flit_width_p+2)-1:0] req_link_sif_o,
  input  logic [wh_flit_width_p+1:0]       mem_link_sif_i,
  output logic [wh_flit_width_p+1:0]       mem_link_sif_o,
  output logic [2*32-1:0]                  pkt_count_o
);

  localparam int          link_w_lp = wh_flit_width_p + 2;
  localparam logic [31:0] split_lp  = 32'(split_cord_p);

  typedef enum logic {eIdle, eLock} state_e;

  logic [1:0]                 req_fwd_v;
  logic [1:0]                 req_ret_ready;
  logic [wh_flit_width_p-1:0] req_fwd_data [2];
  logic                       mem_ret_v;
  logic                       mem_fwd_ready;
  logic [wh_flit_width_p-1:0] mem_ret_data;

  assign req_fwd_v       = {req_link_sif_i[2*link_w_lp-1], req_link_sif_i[link_w_lp-1]};
  assign req_ret_ready   = {req_link_sif_i[link_w_lp], req_link_sif_i[0]};
  assign req_fwd_data[0] = req_link_sif_i[1 +: wh_flit_width_p];
  assign req_fwd_data[1] = req_link_sif_i[link_w_lp+1 +: wh_flit_width_p];
  assign {mem_ret_v, mem_ret_data, mem_fwd_ready} = mem_link_sif_i;

  // Forward path
  state_e                     fwd_state_q;
  logic [wh_len_width_p-1:0]  fwd_cnt_q;
  logic                       fwd_lock_q;
  logic                       rr_last_q;
  logic                       fwd_grant;
  logic                       fwd_v;
  logic                       fwd_hs;
  logic [1:0]                 fwd_ready;
  logic [wh_flit_width_p-1:0] fwd_data;
  logic [wh_len_width_p-1:0]  fwd_len;

  always_comb begin
    fwd_grant = fwd_lock_q;
    if (fwd_state_q == eIdle)
      fwd_grant = (&req_fwd_v) ? ~rr_last_q : req_fwd_v[1];
    fwd_data             = req_fwd_data[fwd_grant];
    fwd_len              = fwd_data[wh_cord_width_p +: wh_len_width_p];
    fwd_v                = req_fwd_v[fwd_grant] & ~reset_i;
    fwd_ready            = '0;
    fwd_ready[fwd_grant] = mem_fwd_ready & ~reset_i;
    fwd_hs               = fwd_v & mem_fwd_ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_state_q <= eIdle;
      fwd_cnt_q   <= '0;
      fwd_lock_q  <= 1'b0;
      rr_last_q   <= 1'b1;
    end else if (fwd_hs) begin
      if (fwd_state_q == eIdle) begin
        rr_last_q <= fwd_grant;
        if (fwd_len != '0) begin
          fwd_state_q <= eLock;
          fwd_cnt_q   <= fwd_len;
          fwd_lock_q  <= fwd_grant;
        end
      end else begin
        fwd_cnt_q <= fwd_cnt_q - 1'b1;
        if (fwd_cnt_q == wh_len_width_p'(1))
          fwd_state_q <= eIdle;
      end
    end
  end

  // Return path
  state_e                    ret_state_q;
  logic [wh_len_width_p-1:0] ret_cnt_q;
  logic                      ret_dest_q;
  logic                      ret_dest;
  logic [1:0]                ret_v;
  logic                      ret_ready;
  logic                      ret_hs;
  logic [wh_len_width_p-1:0] ret_len;

  always_comb begin
    ret_dest = ret_dest_q;
    if (ret_state_q == eIdle)
      ret_dest = (32'(mem_ret_data[wh_cord_width_p-1:0]) >= split_lp);
    ret_v           = '0;
    ret_v[ret_dest] = mem_ret_v & ~reset_i;
    ret_ready       = req_ret_ready[ret_dest] & ~reset_i;
    ret_hs          = mem_ret_v & ret_ready;
    ret_len         = mem_ret_data[wh_cord_width_p +: wh_len_width_p];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ret_state_q <= eIdle;
      ret_cnt_q   <= '0;
      ret_dest_q  <= 1'b0;
    end else if (ret_hs) begin
      if (ret_state_q == eIdle) begin
        if (ret_len != '0) begin
          ret_state_q <= eLock;
          ret_cnt_q   <= ret_len;
          ret_dest_q  <= ret_dest;
        end
      end else begin
        ret_cnt_q <= ret_cnt_q - 1'b1;
        if (ret_cnt_q == wh_len_width_p'(1))
          ret_state_q <= eIdle;
      end
    end
  end

  assign mem_link_sif_o = {fwd_v, fwd_data, ret_ready};
  assign req_link_sif_o = {ret_v[1], mem_ret_data, fwd_ready[1],
                           ret_v[0], mem_ret_data, fwd_ready[0]};

`ifdef BSG_MANYCORE_WH_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [2];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_cnt_q[0] <= '0;
      pkt_cnt_q[1] <= '0;
    end else if (fwd_hs && (fwd_state_q == eIdle)) begin
      pkt_cnt_q[fwd_grant] <= pkt_cnt_q[fwd_grant] + 32'd1;
    end
  end

  assign pkt_count_o = {pkt_cnt_q[1], pkt_cnt_q[0]};
`else
  assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_wh_link_arbiter.sv
// Bench for bsg_manycore_wh_link_arbiter: directed vector table, hand sequences, and random traffic
// against a packet-level reference model. Stats expectations follow BSG_MANYCORE_WH_ARB_STATS_EN.
module tb_bsg_manycore_wh_link_arbiter;

  localparam int F     = 32;
  localparam int C     = 7;
  localparam int L     = 4;
  localparam int SPLIT = 5;
  localparam int W     = F + 2;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [2*W-1:0] req_i, req_o;
  logic [W-1:0]   mem_i, mem_o;
  logic [63:0]    pkt_count_o;

  always #5 clk = ~clk;

  bsg_manycore_wh_link_arbiter #(
    .wh_flit_width_p(F),
    .wh_cord_width_p(C),
    .wh_len_width_p (L),
    .wh_cid_width_p (1),
    .split_cord_p   (SPLIT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_link_sif_i(req_i),
    .req_link_sif_o(req_o),
    .mem_link_sif_i(mem_i),
    .mem_link_sif_o(mem_o),
    .pkt_count_o   (pkt_count_o)
  );

  // stimulus
  logic [1:0]   fv;
  logic [F-1:0] fd [2];
  logic         mfr;
  logic         rv;
  logic [F-1:0] rd;
  logic [1:0]   rr;

  int errors = 0;
  int checks = 0;

  task automatic drive();
    req_i = {fv[1], fd[1], rr[1], fv[0], fd[0], rr[0]};
    mem_i = {rv, rd, mfr};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [F-1:0] hdr(input logic [7:0] tag, input int cord, input int len);
    return {tag, 12'b0, 1'b0, len[3:0], cord[6:0]};
  endfunction

  function automatic logic [F-1:0] rnd_flit();
    logic [F-1:0] f = $urandom;
    int len = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
    int cord = int'($urandom_range(0, 10));
    f[C +: L]  = len[L-1:0];
    f[C-1:0]   = cord[C-1:0];
    return f;
  endfunction

  // DUT output views
  function automatic logic a_mem_v();   return mem_o[W-1];   endfunction
  function automatic logic [F-1:0] a_mem_d(); return mem_o[W-2:1]; endfunction
  function automatic logic a_ret_rdy(); return mem_o[0];     endfunction
  function automatic logic [1:0] a_ret_v();   return {req_o[2*W-1], req_o[W-1]}; endfunction
  function automatic logic [1:0] a_fwd_rdy(); return {req_o[W], req_o[0]};       endfunction
  function automatic logic [F-1:0] a_ret_d(input int p);
    return (p == 1) ? req_o[W+1 +: F] : req_o[1 +: F];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fv = 2'b00; fd[0] = '0; fd[1] = '0; mfr = 1'b0; rv = 1'b0; rd = '0; rr = 2'b00;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    drive();
    tick();
    reset_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   fv;
    logic [F-1:0] d0, d1;
    logic         mfr;
    logic         rv;
    logic [F-1:0] rd;
    logic [1:0]   rr;
    logic         e_mv;
    logic [F-1:0] e_md;
    logic [1:0]   e_frdy;
    logic [1:0]   e_rv;
    logic         e_rrdy;
  } vec_t;

  vec_t tbl [7];

  // reference model: packet owner / flits left / next preferred port
  int          m_fown, m_fleft, m_pref, m_rown, m_rleft;
  logic [31:0] m_cnt [2];

  task automatic model_reset();
    m_fown = -1; m_fleft = 0; m_pref = 0; m_rown = -1; m_rleft = 0;
    m_cnt[0] = '0; m_cnt[1] = '0;
  endtask

  initial begin
    logic [F-1:0] H0, H1, H0b, R0, R2, R3, R4;
    logic [63:0]  exp_cnt;
    int           sent;

    reset_i = 1'b1;
    idle_inputs();
    drive();
    repeat (2) @(posedge clk);
    #1;

    // outputs must stay quiet under reset even with active inputs
    fv = 2'b11; mfr = 1'b1; rv = 1'b1; rr = 2'b11;
    fd[0] = hdr(8'hA0, 1, 0); fd[1] = hdr(8'hA1, 2, 0); rd = hdr(8'hC0, 1, 0);
    drive();
    #1;
    chk("reset_mem_v",    a_mem_v(),   0);
    chk("reset_fwd_rdy",  a_fwd_rdy(), 0);
    chk("reset_ret_v",    a_ret_v(),   0);
    chk("reset_ret_rdy",  a_ret_rdy(), 0);
    tick();
    reset_i = 1'b0;
    idle_inputs();
    drive();
    #1;
    chk("reset_pkt_count", pkt_count_o, 0);

    // vector table: contention with len=2 packets plus concurrent return traffic
    H0  = hdr(8'hA0, 1, 2);
    H1  = hdr(8'hA1, 2, 2);
    H0b = hdr(8'hA2, 3, 0);
    R0  = hdr(8'hC0, 4, 1);
    R2  = hdr(8'hC2, 5, 0);
    R3  = hdr(8'hC3, 6, 0);
    R4  = hdr(8'hC4, 0, 0);
    tbl[0] = '{2'b11, H0,            H1,            1'b1, 1'b1, R0,            2'b11, 1'b1, H0,            2'b01, 2'b01, 1'b1};
    tbl[1] = '{2'b11, 32'hB000_0001, H1,            1'b1, 1'b1, 32'hC100_0000, 2'b11, 1'b1, 32'hB000_0001, 2'b01, 2'b01, 1'b1};
    tbl[2] = '{2'b11, 32'hB000_0002, H1,            1'b1, 1'b1, R2,            2'b11, 1'b1, 32'hB000_0002, 2'b01, 2'b10, 1'b1};
    tbl[3] = '{2'b11, H0b,           H1,            1'b1, 1'b1, R3,            2'b11, 1'b1, H1,            2'b10, 2'b10, 1'b1};
    tbl[4] = '{2'b11, H0b,           32'hB100_0001, 1'b1, 1'b0, R3,            2'b11, 1'b1, 32'hB100_0001, 2'b10, 2'b00, 1'b1};
    tbl[5] = '{2'b11, H0b,           32'hB100_0002, 1'b1, 1'b1, R4,            2'b10, 1'b1, 32'hB100_0002, 2'b10, 2'b01, 1'b0};
    tbl[6] = '{2'b01, H0b,           32'hB100_0002, 1'b1, 1'b1, R4,            2'b01, 1'b1, H0b,           2'b01, 2'b01, 1'b1};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      fv = tbl[i].fv; fd[0] = tbl[i].d0; fd[1] = tbl[i].d1; mfr = tbl[i].mfr;
      rv = tbl[i].rv; rd = tbl[i].rd; rr = tbl[i].rr;
      drive();
      #1;
      chk($sformatf("tbl%0d_mem_v", i), a_mem_v(), tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_mem_d", i), a_mem_d(), tbl[i].e_md);
      chk($sformatf("tbl%0d_fwd_rdy", i), a_fwd_rdy(), tbl[i].e_frdy);
      chk($sformatf("tbl%0d_ret_v", i), a_ret_v(), tbl[i].e_rv);
      if (tbl[i].e_rv != 2'b00)
        chk($sformatf("tbl%0d_ret_d", i), a_ret_d(tbl[i].e_rv[1] ? 1 : 0), tbl[i].rd);
      chk($sformatf("tbl%0d_ret_rdy", i), a_ret_rdy(), tbl[i].e_rrdy);
      tick();
    end

    // port 0 len=3 under stalling mem ready; port 1 waits for all 4 flits
    do_reset();
    sent = 0;
    for (int k = 0; k < 6; k++) begin
      logic [4:0] pat = 5'b11101;
      idle_inputs();
      mfr   = (k < 5) ? pat[k] : 1'b1;
      fv[0] = (sent < 4);
      fd[0] = (sent == 0) ? hdr(8'hA0, 1, 3) : (32'hB000_0000 | 32'(sent));
      fv[1] = (k >= 1);
      fd[1] = hdr(8'hA1, 2, 0);
      drive();
      #1;
      if (sent < 4) begin
        chk($sformatf("lock%0d_p1_rdy", k), a_fwd_rdy(), {1'b0, mfr});
        chk($sformatf("lock%0d_mem_d", k), a_mem_d(), fd[0]);
      end else begin
        chk("lock_p1_grant", a_fwd_rdy(), 2'b10);
        chk("lock_p1_data", a_mem_d(), fd[1]);
      end
      if (fv[0] && mfr) sent++;
      tick();
    end
    chk("lock_p0_flits", sent, 4);

    // reset mid-lock aborts the packet
    do_reset();
    idle_inputs();
    fv = 2'b01; mfr = 1'b1; fd[0] = hdr(8'hA0, 1, 3);
    drive(); tick();
    fd[0] = 32'hB000_0001;
    drive(); tick();
    reset_i = 1'b1; fv = 2'b11; fd[1] = hdr(8'hA1, 2, 0);
    drive();
    #1;
    chk("abort_rst_mem_v", a_mem_v(), 0);
    chk("abort_rst_rdy", a_fwd_rdy(), 0);
    tick();
    reset_i = 1'b0; fv = 2'b10;
    drive();
    #1;
    chk("abort_p1_rdy", a_fwd_rdy(), 2'b10);
    chk("abort_p1_data", a_mem_d(), fd[1]);
    tick();

    // five len=0 packets from port 1
    do_reset();
    idle_inputs();
    fv = 2'b10; mfr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fd[1] = hdr(8'hA1, k, 0);
      drive(); tick();
    end
    idle_inputs();
    drive();
    #1;
`ifdef BSG_MANYCORE_WH_ARB_STATS_EN
    exp_cnt = {32'd5, 32'd0};
`else
    exp_cnt = '0;
`endif
    chk("stats_p1", pkt_count_o[63:32], exp_cnt[63:32]);
    chk("stats_p0", pkt_count_o[31:0],  exp_cnt[31:0]);

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int         p, q, flen, rlen;
      logic       hsf, hsr;
      logic [1:0] oh_p, oh_q;
      reset_i = ($urandom_range(0, 149) == 0);
      for (int j = 0; j < 2; j++) begin
        fv[j] = ($urandom_range(0, 3) != 0);
        fd[j] = rnd_flit();
        rr[j] = ($urandom_range(0, 3) != 0);
      end
      mfr = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      rd  = rnd_flit();
      drive();
      #1;

      p    = (m_fown >= 0) ? m_fown : ((fv == 2'b11) ? m_pref : (fv[1] ? 1 : 0));
      q    = (m_rown >= 0) ? m_rown : ((int'(rd[C-1:0]) >= SPLIT) ? 1 : 0);
      oh_p = (p == 1) ? 2'b10 : 2'b01;
      oh_q = (q == 1) ? 2'b10 : 2'b01;
      flen = int'(fd[p][C +: L]);
      rlen = int'(rd[C +: L]);
      hsf  = !reset_i && fv[p] && mfr;
      hsr  = !reset_i && rv && rr[q];

      chk("rnd_mem_v", a_mem_v(), !reset_i && fv[p]);
      if (!reset_i && fv[p]) chk("rnd_mem_d", a_mem_d(), fd[p]);
      chk("rnd_fwd_rdy", a_fwd_rdy(), (!reset_i && mfr) ? oh_p : 2'b00);
      chk("rnd_ret_v", a_ret_v(), (!reset_i && rv) ? oh_q : 2'b00);
      if (!reset_i && rv) chk("rnd_ret_d", a_ret_d(q), rd);
      chk("rnd_ret_rdy", a_ret_rdy(), !reset_i && rr[q]);
`ifdef BSG_MANYCORE_WH_ARB_STATS_EN
      chk("rnd_pkt_count", pkt_count_o, {m_cnt[1], m_cnt[0]});
`else
      chk("rnd_pkt_count", pkt_count_o, 64'd0);
`endif

      tick();
      if (reset_i) begin
        model_reset();
      end else begin
        if (hsf) begin
          if (m_fown < 0) begin
            m_pref   = 1 - p;
            m_cnt[p] = m_cnt[p] + 32'd1;
            if (flen > 0) begin m_fown = p; m_fleft = flen; end
          end else begin
            m_fleft--;
            if (m_fleft == 0) m_fown = -1;
          end
        end
        if (hsr) begin
          if (m_rown < 0) begin
            if (rlen > 0) begin m_rown = q; m_rleft = rlen; end
          end else begin
            m_rleft--;
            if (m_rleft == 0) m_rown = -1;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
